// File: rtl/ped_xing_pkg.sv
// Shared state codes and lamp patterns for the pedestrian crossing controller.
// Lamp vectors are packed as {sv, sa, sr, pv, pr}.
package ped_xing_pkg;

   typedef enum logic [2:0] {
      ST_CLEAR      = 3'd0,
      ST_GREEN      = 3'd1,
      ST_GREEN_WAIT = 3'd2,
      ST_AMBER      = 3'd3,
      ST_WALK       = 3'd4,
      ST_FLASH      = 3'd5,
      ST_NIGHT      = 3'd6
   } state_t;

   localparam logic [4:0] LAMP_CLEAR = 5'b00101;
   localparam logic [4:0] LAMP_GREEN = 5'b10001;
   localparam logic [4:0] LAMP_AMBER = 5'b01001;
   localparam logic [4:0] LAMP_WALK  = 5'b00110;
   localparam logic [4:0] LAMP_FLASH = 5'b00100;
   localparam logic [4:0] LAMP_NIGHT = 5'b00000;

   // Blinking lamps (pv in FLASH, sa in NIGHT) are overlaid from the blink phase.
   function automatic logic [4:0] lamp_vec(input state_t st, input logic blink);
      logic [4:0] v;
      v = LAMP_CLEAR;
      case (st)
         ST_CLEAR:      v = LAMP_CLEAR;
         ST_GREEN:      v = LAMP_GREEN;
         ST_GREEN_WAIT: v = LAMP_GREEN;
         ST_AMBER:      v = LAMP_AMBER;
         ST_WALK:       v = LAMP_WALK;
         ST_FLASH:      v = LAMP_FLASH | {3'b000, blink, 1'b0};
         ST_NIGHT:      v = LAMP_NIGHT | {1'b0, blink, 3'b000};
         default:       v = LAMP_CLEAR;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Per-button 2-FF synchroniser, stable-time debouncer and one-cycle press pulse.
// Button is active low; reset leaves it in the released state.
module btn_debounce #(
   parameter int DEB_T = 20
) (
   input  logic clk,
   input  logic rstn,
   input  logic btn_n,
   output logic press
);

   localparam int DW = (DEB_T > 1) ? $clog2(DEB_T) : 1;
   localparam logic [DW-1:0] DEB_M1 = DW'(DEB_T - 1);

   logic          sync1_reg;
   logic          sync2_reg;
   logic          level_reg;
   logic          press_reg;
   logic [DW-1:0] cnt_reg;

   // The counter tracks consecutive samples that disagree with the debounced level.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_reg <= 1'b1;
         sync2_reg <= 1'b1;
         level_reg <= 1'b1;
         press_reg <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         sync1_reg <= btn_n;
         sync2_reg <= sync1_reg;
         press_reg <= 1'b0;
         if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == DEB_M1) begin
            level_reg <= sync2_reg;
            cnt_reg   <= '0;
            press_reg <= ~sync2_reg;
         end else begin
            cnt_reg <= cnt_reg + DW'(1);
         end
      end
   end

   assign press = press_reg;

endmodule

// File: rtl/ped_xing_ctrl.sv
// Moore pedestrian-crossing controller: vehicle/pedestrian lamps, request latch,
// all-red clearance and flashing-amber night mode. One clock cycle is one tick.
module ped_xing_ctrl
   import ped_xing_pkg::*;
#(
   parameter int NBTN    = 2,
   parameter int CNT_W   = 17,
   parameter int T_CLEAR = 2000,
   parameter int T_GREEN = 60000,
   parameter int T_AMBER = 5000,
   parameter int T_WALK  = 20000,
   parameter int T_FLASH = 5000,
   parameter int T_HALF  = 250,
   parameter int DEB_T   = 20
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [NBTN-1:0] btn_n,
   input  logic            night,
   output logic            sv,
   output logic            sa,
   output logic            sr,
   output logic            pv,
   output logic            pr,
   output logic            req_lamp,
   output logic [2:0]      state_o
);

   localparam int BLK_W = (T_HALF > 1) ? $clog2(T_HALF) : 1;
   localparam logic [CNT_W-1:0] CLEAR_M1 = CNT_W'(T_CLEAR - 1);
   localparam logic [CNT_W-1:0] GREEN_M1 = CNT_W'(T_GREEN - 1);
   localparam logic [CNT_W-1:0] AMBER_M1 = CNT_W'(T_AMBER - 1);
   localparam logic [CNT_W-1:0] WALK_M1  = CNT_W'(T_WALK - 1);
   localparam logic [CNT_W-1:0] FLASH_M1 = CNT_W'(T_FLASH - 1);
   localparam logic [BLK_W-1:0] HALF_M1  = BLK_W'(T_HALF - 1);

   logic [NBTN-1:0] press;
   logic            any_press;
   logic            night_s1_reg;
   logic            night_s2_reg;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [BLK_W-1:0]   blink_cnt_reg, blink_cnt_next;
   logic               blink_reg, blink_next;
   logic               req_reg, req_next;
   logic [4:0]         lamp_reg, lamp_next;
   logic               entry;
   logic               blink_on;

   genvar gi;
   generate
      for (gi = 0; gi < NBTN; gi++) begin : g_btn
         btn_debounce #(.DEB_T(DEB_T)) u_deb (
            .clk   (clk),
            .rstn  (rstn),
            .btn_n (btn_n[gi]),
            .press (press[gi])
         );
      end
   endgenerate

   assign any_press = |press;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         night_s1_reg <= 1'b0;
         night_s2_reg <= 1'b0;
      end else begin
         night_s1_reg <= night;
         night_s2_reg <= night_s1_reg;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_CLEAR:      if (cnt_reg == CLEAR_M1) state_next = ST_GREEN;
         ST_GREEN: begin
            if (night_s2_reg)            state_next = ST_NIGHT;
            else if (cnt_reg == GREEN_M1) state_next = ST_GREEN_WAIT;
         end
         ST_GREEN_WAIT: begin
            if (night_s2_reg)              state_next = ST_NIGHT;
            else if (req_reg || any_press) state_next = ST_AMBER;
         end
         ST_AMBER:      if (cnt_reg == AMBER_M1) state_next = ST_WALK;
         ST_WALK:       if (cnt_reg == WALK_M1)  state_next = ST_FLASH;
         ST_FLASH:      if (cnt_reg == FLASH_M1) state_next = ST_CLEAR;
         ST_NIGHT:      if (!night_s2_reg)       state_next = ST_CLEAR;
         default:       state_next = ST_CLEAR;
      endcase

      entry = (state_next != state_reg);

      // Open-ended states hold the counter so it cannot wrap while waiting.
      cnt_next = cnt_reg + CNT_W'(1);
      if (entry)
         cnt_next = '0;
      else if (state_reg == ST_GREEN_WAIT || state_reg == ST_NIGHT)
         cnt_next = cnt_reg;

      blink_on       = (state_next == ST_FLASH) || (state_next == ST_NIGHT);
      blink_cnt_next = '0;
      blink_next     = 1'b1;
      if (blink_on && !entry) begin
         if (blink_cnt_reg == HALF_M1) begin
            blink_cnt_next = '0;
            blink_next     = ~blink_reg;
         end else begin
            blink_cnt_next = blink_cnt_reg + BLK_W'(1);
            blink_next     = blink_reg;
         end
      end

      req_next = req_reg;
      if (entry && (state_next == ST_AMBER || state_next == ST_NIGHT))
         req_next = 1'b0;
      else if ((state_reg == ST_GREEN || state_reg == ST_GREEN_WAIT) && any_press)
         req_next = 1'b1;

      lamp_next = lamp_vec(state_next, blink_next);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg     <= ST_CLEAR;
         cnt_reg       <= '0;
         blink_cnt_reg <= '0;
         blink_reg     <= 1'b1;
         req_reg       <= 1'b0;
         lamp_reg      <= LAMP_CLEAR;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         blink_cnt_reg <= blink_cnt_next;
         blink_reg     <= blink_next;
         req_reg       <= req_next;
         lamp_reg      <= lamp_next;
      end
   end

   assign {sv, sa, sr, pv, pr} = lamp_reg;
   assign req_lamp             = req_reg;
   assign state_o              = state_reg;

endmodule

// File: tb/tb_ped_xing_ctrl.sv
// Bench for ped_xing_ctrl: abstract cycle model checked every cycle, plus
// hand-computed literal expectations along the directed scenarios.
module tb_ped_xing_ctrl;

   localparam int NBTN    = 2;
   localparam int T_CLEAR = 2;
   localparam int T_GREEN = 10;
   localparam int T_AMBER = 3;
   localparam int T_WALK  = 5;
   localparam int T_FLASH = 4;
   localparam int T_HALF  = 2;
   localparam int DEB_T   = 3;
   localparam int HD      = DEB_T + 2;

   localparam int S_CLEAR = 0, S_GREEN = 1, S_GW = 2, S_AMBER = 3,
                  S_WALK = 4, S_FLASH = 5, S_NIGHT = 6;

   logic            clk;
   logic            rstn;
   logic [NBTN-1:0] btn_n;
   logic            night;
   logic            sv, sa, sr, pv, pr, req_lamp;
   logic [2:0]      state_o;

   ped_xing_ctrl #(
      .NBTN(NBTN), .CNT_W(8), .T_CLEAR(T_CLEAR), .T_GREEN(T_GREEN),
      .T_AMBER(T_AMBER), .T_WALK(T_WALK), .T_FLASH(T_FLASH),
      .T_HALF(T_HALF), .DEB_T(DEB_T)
   ) dut (
      .clk(clk), .rstn(rstn), .btn_n(btn_n), .night(night),
      .sv(sv), .sa(sa), .sr(sr), .pv(pv), .pr(pr),
      .req_lamp(req_lamp), .state_o(state_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   bit mon_en   = 0;

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s (cycle %0d): got %03h, required %03h", name, cyc, act, exp);
   endtask

   function automatic logic [4:0] lamps();
      return {sv, sa, sr, pv, pr};
   endfunction

   // ---------------- behavioural model ----------------
   int              m_state;
   int              m_t;
   bit              m_req;
   logic [NBTN-1:0] m_deb;
   logic [NBTN-1:0] m_press;
   logic [NBTN-1:0] hist [HD];
   logic            nh [3];

   task automatic model_reset();
      m_state = S_CLEAR;
      m_t     = 0;
      m_req   = 0;
      m_deb   = '1;
      m_press = '0;
      for (int k = 0; k < HD; k++) hist[k] = '1;
      for (int k = 0; k < 3; k++) nh[k] = 1'b0;
   endtask

   function automatic int phase_len(input int s);
      case (s)
         S_CLEAR: return T_CLEAR;
         S_GREEN: return T_GREEN;
         S_AMBER: return T_AMBER;
         S_WALK:  return T_WALK;
         S_FLASH: return T_FLASH;
         default: return 0;
      endcase
   endfunction

   task automatic model_step();
      int nxt;
      bit ns, anyp, stable;
      for (int k = HD - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = btn_n;
      nh[2] = nh[1]; nh[1] = nh[0]; nh[0] = night;
      ns   = nh[2];
      anyp = |m_press;
      nxt  = m_state;
      case (m_state)
         S_GREEN:  if (ns) nxt = S_NIGHT; else if (m_t + 1 == T_GREEN) nxt = S_GW;
         S_GW:     if (ns) nxt = S_NIGHT; else if (m_req || anyp) nxt = S_AMBER;
         S_NIGHT:  if (!ns) nxt = S_CLEAR;
         default:  if (m_t + 1 == phase_len(m_state))
                      nxt = (m_state == S_FLASH) ? S_CLEAR : m_state + 1;
      endcase
      if (nxt != m_state && (nxt == S_AMBER || nxt == S_NIGHT)) m_req = 0;
      else if ((m_state == S_GREEN || m_state == S_GW) && anyp) m_req = 1;
      m_t     = (nxt != m_state) ? 0 : m_t + 1;
      m_state = nxt;
      // a button flips only when the last DEB_T synchronised samples all disagree
      for (int b = 0; b < NBTN; b++) begin
         stable = 1;
         for (int k = 2; k < HD; k++) if (hist[k][b] == m_deb[b]) stable = 0;
         m_press[b] = 1'b0;
         if (stable) begin
            m_deb[b]   = ~m_deb[b];
            m_press[b] = ~m_deb[b];
         end
      end
   endtask

   function automatic logic [11:0] model_vec();
      logic [4:0] l;
      logic       blink;
      blink = ((m_t / T_HALF) % 2) == 0;
      case (m_state)
         S_CLEAR:        l = 5'b00101;
         S_GREEN, S_GW:  l = 5'b10001;
         S_AMBER:        l = 5'b01001;
         S_WALK:         l = 5'b00110;
         S_FLASH:        l = {3'b001, blink, 1'b0};
         default:        l = {1'b0, blink, 3'b000};
      endcase
      return {l, m_req, 3'(m_state)};
   endfunction

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rstn);
         if (!rstn) model_reset();
         else model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (mon_en) chk("model", {lamps(), req_lamp, state_o}, model_vec());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required finish within 100000 time units");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string name);
      bit seen;
      seen = 0;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge clk);
         if (state_o == s) seen = 1;
      end
      n_checks++;
      if (seen) n_pass++;
      else $display("FAIL %s: state_o=%0d after %0d cycles, required %0d", name, state_o, budget, s);
   endtask

   initial begin
      rstn  = 1'b0;
      btn_n = '1;
      night = 1'b0;
      step(3);
      mon_en = 1;
      rstn   = 1'b1;

      $display("txn 1: reset release, idle sequence");
      step(1);  chk("clear_cycle2_state", 12'(state_o), 12'd0);
      chk("clear_lamps", 12'(lamps()), 12'(5'b00101));
      step(1);  chk("green_cycle1_state", 12'(state_o), 12'd1);
      step(9);  chk("green_cycle10_state", 12'(state_o), 12'd1);
      step(1);  chk("green_wait_state", 12'(state_o), 12'd2);
      step(4);  chk("green_wait_lamps", 12'({lamps(), req_lamp}), 12'(6'b100010));

      $display("txn 3: 2-cycle bounce on btn1 in GREEN_WAIT");
      btn_n[1] = 1'b0; step(2); btn_n[1] = 1'b1;
      step(10); chk("bounce_no_press", 12'({req_lamp, state_o}), 12'(4'b0010));

      $display("txn: press in GREEN_WAIT");
      btn_n[0] = 1'b0;
      wait_state(3'd3, 20, "gw_press_amber");
      chk("gw_press_req_clear", 12'(req_lamp), 12'd0);
      step(1); btn_n[0] = 1'b1;

      $display("txn 2: held press in GREEN cycle 2");
      wait_state(3'd1, 40, "reach_green");
      step(1);  btn_n[0] = 1'b0;
      step(5);  chk("req_before_latency", 12'(req_lamp), 12'd0);
      step(1);  chk("req_after_latency", 12'(req_lamp), 12'd1);
      step(2);  chk("green_cycle10_req", 12'({req_lamp, state_o}), 12'(4'b1001));
      step(1);  chk("gw_with_req", 12'({req_lamp, state_o}), 12'(4'b1010));
      step(1);  chk("amber_entry", 12'({lamps(), req_lamp, state_o}), 12'({5'b01001, 1'b0, 3'd3}));
      step(3);  chk("walk_entry", 12'({lamps(), state_o}), 12'({5'b00110, 3'd4}));

      $display("txn 4: press during WALK is ignored");
      btn_n[1] = 1'b0; btn_n[0] = 1'b1;
      step(5);  chk("flash_pv1", 12'({lamps(), state_o}), 12'({5'b00110, 3'd5}));
      step(1);  chk("flash_pv2", 12'(pv), 12'd1);
      step(1);  chk("flash_pv3", 12'({lamps(), state_o}), 12'({5'b00100, 3'd5}));
      step(1);  chk("flash_pv4", 12'(pv), 12'd0);
      step(1);  chk("flash_to_clear", 12'(state_o), 12'd0);
      btn_n[1] = 1'b1;
      wait_state(3'd2, 20, "reach_gw_after_walk_press");
      chk("walk_press_ignored", 12'(req_lamp), 12'd0);
      step(5);  chk("gw_stays", 12'(state_o), 12'd2);

      $display("txn 5: night asserted during AMBER");
      btn_n[0] = 1'b0;
      wait_state(3'd3, 20, "night_run_amber");
      btn_n[0] = 1'b1; night = 1'b1;
      wait_state(3'd1, 40, "night_run_green");
      step(1);  chk("night_entry", 12'({lamps(), req_lamp, state_o}), 12'({5'b01000, 1'b0, 3'd6}));
      step(1);  chk("night_sa_t1", 12'(lamps()), 12'(5'b01000));
      step(1);  chk("night_sa_t2", 12'(lamps()), 12'(5'b00000));
      step(1);  chk("night_sa_t3", 12'(sa), 12'd0);
      step(1);  chk("night_sa_t4", 12'(sa), 12'd1);
      night = 1'b0;
      wait_state(3'd0, 10, "night_exit_clear");
      wait_state(3'd1, 10, "night_exit_green");

      $display("txn 6: reset pulse during WALK");
      btn_n[1] = 1'b0;
      wait_state(3'd4, 40, "reset_run_walk");
      btn_n[1] = 1'b1;
      step(2);
      @(posedge clk); #2 rstn = 1'b0;
      #1;
      chk("async_reset_out", 12'({lamps(), req_lamp, state_o}), 12'({5'b00101, 1'b0, 3'd0}));
      @(negedge clk); rstn = 1'b1;
      step(1);  chk("post_reset_clear", 12'(state_o), 12'd0);
      step(1);  chk("post_reset_green", 12'({req_lamp, state_o}), 12'(4'b0001));
      step(3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
